// File: rtl/ids_pkt_gen.sv
// ids_pkt_gen: test-packet transmitter for the user data path.
//
// Each packet is one module-header word, three header words and P payload
// words. A 7-byte pattern can be placed in one chosen payload word. Between
// packets the block waits IFG_CYCLES idle cycles.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   out_data/out_ctrl   registered packet word and its ctrl byte
//   out_wr              registered word strobe
//   out_rdy             downstream can take a word this cycle
//   gen_start           pulse: latch cfg_* and start generating
//   gen_stop            pulse: finish the current packet, then go idle
//   clr_counters        pulse: zero pkts_sent and the sequence number
//   cfg_pkt_count       packets to send (0 = continuous)
//   cfg_payload_words   payload words per packet (0 behaves as 1)
//   cfg_insert_word     payload word index that carries the pattern
//   cfg_pattern         7-byte pattern
//   busy                generator is not idle
//   pkts_sent           completed packets, wrapping
//   gen_la_data         debug bus
//   gen_la_trigger      debug trigger
//
// Build option: define IDS_PKT_GEN_LA_EN to drive the debug bus; otherwise
// gen_la_data and gen_la_trigger are tied to zero.
module ids_pkt_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 8,
  parameter int IFG_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  gen_start,
  input  logic                  gen_stop,
  input  logic                  clr_counters,
  input  logic [15:0]           cfg_pkt_count,
  input  logic [LEN_WIDTH-1:0]  cfg_payload_words,
  input  logic [LEN_WIDTH-1:0]  cfg_insert_word,
  input  logic [55:0]           cfg_pattern,
  output logic                  busy,
  output logic [31:0]           pkts_sent,
  output logic [71:0]           gen_la_data,
  output logic                  gen_la_trigger
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MODHDR  = 3'd1,
    S_HDR     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [15:0]          GAP_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [1:0]             r_hdr_idx;
  logic [LEN_WIDTH-1:0]   r_pl_idx;
  logic [15:0]            r_gap_cnt;
  logic [15:0]            r_remaining;
  logic                   r_finite;
  logic                   r_stop_pending;
  logic [LEN_WIDTH-1:0]   r_pl_words;
  logic [LEN_WIDTH-1:0]   r_insert_word;
  logic [55:0]            r_pattern;
  logic [15:0]            r_seq_num;
  logic [15:0]            r_pkt_seq;
  logic [31:0]            r_pkts_sent;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [CTRL_WIDTH-1:0]  r_out_ctrl;
  logic                   r_out_wr;

  logic                   w_sending;
  logic                   w_emit;
  logic                   w_pl_last;
  logic                   w_eop;
  logic                   w_stop_any;
  logic                   w_halt_gap;
  logic                   w_halt_eop;
  logic [15:0]            w_byte_len;
  logic [39:0]            w_pl_idx_ext;
  logic [LEN_WIDTH-1:0]   w_pl_words_eff;
  logic [63:0]            w_word_data;
  logic [7:0]             w_word_ctrl;
  logic [DATA_WIDTH-1:0]  w_out_data_next;
  logic [CTRL_WIDTH-1:0]  w_out_ctrl_next;

  assign w_sending      = (r_state == S_MODHDR) || (r_state == S_HDR) || (r_state == S_PAYLOAD);
  assign w_emit         = w_sending && out_rdy;
  assign w_pl_last      = (r_pl_idx == (r_pl_words - LEN_ONE));
  assign w_eop          = w_emit && (r_state == S_PAYLOAD) && w_pl_last;
  assign w_stop_any     = r_stop_pending || gen_stop;
  // Decision at the end of the gap: remaining was already decremented at EOP.
  assign w_halt_gap     = w_stop_any || (r_finite && (r_remaining == 16'd0));
  // Same decision taken at EOP when there is no gap; remaining is about to drop.
  assign w_halt_eop     = w_stop_any || (r_finite && (r_remaining <= 16'd1));
  assign w_byte_len     = (16'(r_pl_words) + 16'd3) << 3;
  assign w_pl_idx_ext   = 40'(r_pl_idx);
  assign w_pl_words_eff = (cfg_payload_words == '0) ? LEN_ONE : cfg_payload_words;

  // Word presented in the current state; it is registered only when emitted.
  always_comb begin
    w_word_data = 64'h0;
    w_word_ctrl = 8'h00;
    case (r_state)
      S_MODHDR: begin
        w_word_data = {48'h0, w_byte_len};
        w_word_ctrl = 8'hFF;
      end
      S_HDR: begin
        w_word_data = {16'hA5A5, r_pkt_seq, 29'h0, 1'b0, r_hdr_idx};
      end
      S_PAYLOAD: begin
        if (r_pl_idx == r_insert_word) w_word_data = {r_pattern, 8'h00};
        else                           w_word_data = {r_pkt_seq, 8'h5A, w_pl_idx_ext};
        w_word_ctrl = w_pl_last ? 8'h01 : 8'h00;
      end
      default: ;
    endcase
  end

  assign w_out_data_next = w_emit ? w_word_data : r_out_data;
  assign w_out_ctrl_next = w_emit ? w_word_ctrl : r_out_ctrl;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (gen_start) w_state_next = S_MODHDR;
      S_MODHDR:  if (out_rdy) w_state_next = S_HDR;
      S_HDR:     if (out_rdy && (r_hdr_idx == 2'd2)) w_state_next = S_PAYLOAD;
      S_PAYLOAD: begin
        if (w_eop) begin
          if (IFG_CYCLES == 0) w_state_next = w_halt_eop ? S_IDLE : S_MODHDR;
          else                 w_state_next = S_GAP;
        end
      end
      S_GAP:     if (r_gap_cnt == GAP_LAST) w_state_next = w_halt_gap ? S_IDLE : S_MODHDR;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hdr_idx      <= '0;
      r_pl_idx       <= '0;
      r_gap_cnt      <= '0;
      r_remaining    <= '0;
      r_finite       <= 1'b0;
      r_stop_pending <= 1'b0;
      r_pl_words     <= LEN_ONE;
      r_insert_word  <= '0;
      r_pattern      <= '0;
      r_seq_num      <= '0;
      r_pkt_seq      <= '0;
      r_pkts_sent    <= '0;
      r_out_data     <= '0;
      r_out_ctrl     <= '0;
      r_out_wr       <= 1'b0;
    end else begin
      r_out_wr   <= w_emit;
      r_out_data <= w_out_data_next;
      r_out_ctrl <= w_out_ctrl_next;

      if ((r_state == S_IDLE) && gen_start) begin
        r_remaining   <= cfg_pkt_count;
        r_finite      <= (cfg_pkt_count != 16'd0);
        r_pl_words    <= w_pl_words_eff;
        r_insert_word <= cfg_insert_word;
        r_pattern     <= cfg_pattern;
      end else if (w_eop && (r_remaining != 16'd0)) begin
        r_remaining <= r_remaining - 16'd1;
      end

      if (w_emit && (r_state == S_MODHDR))    r_hdr_idx <= 2'd0;
      else if (w_emit && (r_state == S_HDR))  r_hdr_idx <= r_hdr_idx + 2'd1;

      if (w_emit && (r_state == S_HDR) && (r_hdr_idx == 2'd2)) r_pl_idx <= '0;
      else if (w_emit && (r_state == S_PAYLOAD))               r_pl_idx <= r_pl_idx + LEN_ONE;

      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 16'd1;
      else                  r_gap_cnt <= 16'd0;

      if (w_state_next == S_IDLE)               r_stop_pending <= 1'b0;
      else if (gen_stop && (r_state != S_IDLE)) r_stop_pending <= 1'b1;

      // Snapshot the sequence number for the whole packet before its headers
      // go out, so a clear mid-packet does not change the packet's own words.
      if (r_state == S_MODHDR) r_pkt_seq <= r_seq_num;

      // Clear takes priority over a coincident EOP increment.
      if (clr_counters) begin
        r_seq_num   <= '0;
        r_pkts_sent <= '0;
      end else if (w_eop) begin
        r_seq_num   <= r_seq_num + 16'd1;
        r_pkts_sent <= r_pkts_sent + 32'd1;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ctrl  = r_out_ctrl;
  assign out_wr    = r_out_wr;
  assign busy      = (r_state != S_IDLE);
  assign pkts_sent = r_pkts_sent;

`ifdef IDS_PKT_GEN_LA_EN
  logic [71:0] r_la_data;
  logic        r_la_trig;

  // The field list is 74 bits; the 72-bit bus keeps the low 72, so the top
  // two ctrl bits are not visible (ctrl only ever uses 0xFF/0x01/0x00).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_la_data <= '0;
      r_la_trig <= 1'b0;
    end else begin
      r_la_data <= {w_out_ctrl_next[5:0], w_out_data_next[63:32], r_state, 1'b0, r_hdr_idx,
                    8'(r_pl_idx), (r_state != S_IDLE), r_stop_pending, out_rdy, w_emit, 16'h0};
      r_la_trig <= w_emit;
    end
  end

  assign gen_la_data    = r_la_data;
  assign gen_la_trigger = r_la_trig;
`else
  assign gen_la_data    = 72'h0;
  assign gen_la_trigger = 1'b0;
`endif

endmodule

// File: tb/tb_ids_pkt_gen.sv
// Self-checking bench for ids_pkt_gen (default parameters, IFG_CYCLES = 4).
// Expected words are pushed to exp_q when a packet is started; a monitor
// collects emitted words into act_q and each test pops and compares them.
module tb_ids_pkt_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        gen_start;
  logic        gen_stop;
  logic        clr_counters;
  logic [15:0] cfg_pkt_count;
  logic [7:0]  cfg_payload_words;
  logic [7:0]  cfg_insert_word;
  logic [55:0] cfg_pattern;
  logic        busy;
  logic [31:0] pkts_sent;
  logic [71:0] gen_la_data;
  logic        gen_la_trigger;

  ids_pkt_gen dut (
    .clk(clk), .reset(reset), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .gen_start(gen_start), .gen_stop(gen_stop), .clr_counters(clr_counters),
    .cfg_pkt_count(cfg_pkt_count), .cfg_payload_words(cfg_payload_words),
    .cfg_insert_word(cfg_insert_word), .cfg_pattern(cfg_pattern), .busy(busy),
    .pkts_sent(pkts_sent), .gen_la_data(gen_la_data), .gen_la_trigger(gen_la_trigger)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bp_viol = 0;
  logic last_rdy = 1'b0;
  logic [71:0] exp_q[$];
  logic [71:0] act_q[$];
  int          act_cyc[$];

  localparam logic [55:0] PAT = 56'h11223344556677;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_rdy <= out_rdy;
  end

  always @(negedge clk) begin
    if (out_wr) begin
      act_q.push_back({out_ctrl, out_data});
      act_cyc.push_back(cyc);
      if (!last_rdy) bp_viol++;
    end
  end

  // Reference packet built directly from the packet format description.
  task automatic push_pkt(input logic [15:0] seq, input int pw_cfg, input int ins, input logic [55:0] pat);
    int p;
    logic [15:0] bl;
    logic [63:0] d;
    p  = (pw_cfg == 0) ? 1 : pw_cfg;
    bl = 16'((3 + p) * 8);
    exp_q.push_back({8'hFF, 48'h0, bl});
    for (int h = 0; h < 3; h++) exp_q.push_back({8'h00, 16'hA5A5, seq, 29'h0, 3'(h)});
    for (int i = 0; i < p; i++) begin
      d = (i == ins) ? {pat, 8'h00} : {seq, 8'h5A, 40'(i)};
      exp_q.push_back({(i == p - 1) ? 8'h01 : 8'h00, d});
    end
  endtask

  task automatic start_gen(input logic [15:0] cnt, input logic [7:0] pw, input logic [7:0] ins, input logic [55:0] pat);
    @(negedge clk);
    cfg_pkt_count = cnt; cfg_payload_words = pw; cfg_insert_word = ins; cfg_pattern = pat;
    gen_start = 1'b1;
    @(negedge clk);
    gen_start = 1'b0;
    // Scramble the config so only latched values can produce correct words.
    cfg_pkt_count = 16'd9; cfg_payload_words = pw + 8'd3; cfg_insert_word = 8'd0; cfg_pattern = ~pat;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_counters = 1'b1;
    @(negedge clk); clr_counters = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
      if (toggle) out_rdy = ~out_rdy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; gen_start = 0; gen_stop = 0; clr_counters = 0; out_rdy = 1'b1;
    cfg_pkt_count = 0; cfg_payload_words = 0; cfg_insert_word = 0; cfg_pattern = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (out_wr !== 1'b0)     begin errors++; $display("FAIL reset_out_wr: got %b expected 0", out_wr); end
    checks++; if (out_data !== 64'h0)  begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_ctrl !== 8'h0)   begin errors++; $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pkts_sent !== 32'h0) begin errors++; $display("FAIL reset_pkts_sent: got %0d expected 0", pkts_sent); end
    checks++; if ({gen_la_data, gen_la_trigger} !== 73'h0) begin errors++; $display("FAIL reset_la: got %h expected 0", {gen_la_data, gen_la_trigger}); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [71:0] e, a;
    act_q.delete(); act_cyc.delete(); exp_q.delete();
    push_pkt(16'd0, 2, 0, PAT);
    start_gen(16'd1, 8'd2, 8'd0, PAT);
    wait_idle(100, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: busy stuck 1, expected 0"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin errors++; $display("FAIL basic_word: missing, expected %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin errors++; $display("FAIL basic_word: got %h expected %h", a, e); end end
    end
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL basic_extra: got %0d extra words expected 0", act_q.size()); end
    checks++; if (pkts_sent !== 32'd1) begin errors++; $display("FAIL basic_pkts_sent: got %0d expected 1", pkts_sent); end
    $display("basic: packet of 6 words, pkts_sent=%0d", pkts_sent);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [71:0] e, a;
    pulse_clr();
    checks++; if (pkts_sent !== 32'd0) begin errors++; $display("FAIL clr_pkts_sent: got %0d expected 0", pkts_sent); end
    act_q.delete(); act_cyc.delete(); exp_q.delete(); bp_viol = 0;
    push_pkt(16'd0, 2, 0, PAT);
    start_gen(16'd1, 8'd2, 8'd0, PAT);
    wait_idle(200, 1'b1, ok);
    out_rdy = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: busy stuck 1, expected 0"); end
    checks++; if (bp_viol !== 0) begin errors++; $display("FAIL bp_rdy: got %0d words after out_rdy=0, expected 0", bp_viol); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin errors++; $display("FAIL bp_word: missing, expected %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin errors++; $display("FAIL bp_word: got %h expected %h", a, e); end end
    end
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL bp_extra: got %0d extra words expected 0", act_q.size()); end
    $display("backpressure: packet done, pkts_sent=%0d", pkts_sent);
  endtask

  task automatic test_multi();
    bit ok;
    logic [71:0] e, a;
    int c, prev_c;
    pulse_clr();
    act_q.delete(); act_cyc.delete(); exp_q.delete();
    for (int k = 0; k < 3; k++) push_pkt(16'(k), 2, 1, PAT);
    start_gen(16'd3, 8'd2, 8'd1, PAT);
    wait_idle(300, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_timeout: busy stuck 1, expected 0"); end
    prev_c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin errors++; $display("FAIL multi_word: missing, expected %h", e); end
      else begin
        a = act_q.pop_front(); c = act_cyc.pop_front();
        if (a !== e) begin errors++; $display("FAIL multi_word: got %h expected %h", a, e); end
        if (e[71:64] == 8'hFF && prev_c != 0) begin
          checks++;
          if (c - prev_c != 5) begin errors++; $display("FAIL multi_gap: got %0d idle cycles expected 4", c - prev_c - 1); end
        end
        prev_c = c;
      end
    end
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL multi_extra: got %0d extra words expected 0", act_q.size()); end
    checks++; if (pkts_sent !== 32'd3) begin errors++; $display("FAIL multi_pkts_sent: got %0d expected 3", pkts_sent); end
    $display("multi: 3 packets, pkts_sent=%0d", pkts_sent);
  endtask

  task automatic test_stop();
    bit ok, stopped;
    logic [71:0] e, a;
    pulse_clr();
    act_q.delete(); act_cyc.delete(); exp_q.delete();
    for (int k = 0; k < 5; k++) push_pkt(16'(k), 4, 2, PAT);
    start_gen(16'd0, 8'd4, 8'd2, PAT);
    ok = 1'b0; stopped = 1'b0;
    // Packets are 8 words; words 36..39 are the payload of packet 5.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      gen_stop = 1'b0;
      if (!stopped && act_q.size() >= 37) begin gen_stop = 1'b1; stopped = 1'b1; end
      if (!busy) begin ok = 1'b1; break; end
    end
    gen_stop = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stop_timeout: busy stuck 1, expected 0"); end
    repeat (20) @(negedge clk);
    checks++; if (act_q.size() != 40) begin errors++; $display("FAIL stop_count: got %0d words expected 40", act_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin errors++; $display("FAIL stop_word: missing, expected %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin errors++; $display("FAIL stop_word: got %h expected %h", a, e); end end
    end
    checks++; if (pkts_sent !== 32'd5) begin errors++; $display("FAIL stop_pkts_sent: got %0d expected 5", pkts_sent); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", busy); end
    $display("stop: continuous run stopped, pkts_sent=%0d", pkts_sent);
  endtask

  task automatic test_boundary();
    bit ok;
    logic [71:0] e, a;
    pulse_clr();
    act_q.delete(); act_cyc.delete(); exp_q.delete();
    push_pkt(16'd0, 0, 7, PAT);
    start_gen(16'd1, 8'd0, 8'd7, PAT);
    wait_idle(100, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bound_timeout: busy stuck 1, expected 0"); end
    checks++; if (act_q.size() == 0 || act_q[0][15:0] !== 16'h0020) begin errors++; $display("FAIL bound_len: got %0d words / first %h, expected byte_len 0020", act_q.size(), act_q.size() ? act_q[0] : 72'h0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin errors++; $display("FAIL bound_word: missing, expected %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin errors++; $display("FAIL bound_word: got %h expected %h", a, e); end end
    end
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL bound_extra: got %0d extra words expected 0", act_q.size()); end
    $display("boundary: payload=0 packet done, pkts_sent=%0d", pkts_sent);
  endtask

  task automatic test_reset_clear();
    bit ok, found;
    logic [71:0] e, a;
    // Reset while a header word is on the bus.
    act_q.delete(); act_cyc.delete(); exp_q.delete();
    start_gen(16'd1, 8'd2, 8'd0, PAT);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_wr && out_ctrl == 8'h00 && out_data[63:48] == 16'hA5A5) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_hdr_seen: got no header word, expected one"); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_wr !== 1'b0)     begin errors++; $display("FAIL rst_mid_wr: got %b expected 0", out_wr); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (pkts_sent !== 32'd0) begin errors++; $display("FAIL rst_mid_pkts: got %0d expected 0", pkts_sent); end
    reset = 1'b0;
    @(negedge clk);
    // clr_counters coincident with the EOP edge; both packets must carry seq 0.
    act_q.delete(); act_cyc.delete(); exp_q.delete();
    push_pkt(16'd0, 1, 5, PAT);
    push_pkt(16'd0, 1, 5, PAT);
    start_gen(16'd1, 8'd1, 8'd5, PAT);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_wr && out_ctrl == 8'h00 && out_data[63:48] == 16'hA5A5 && out_data[2:0] == 3'd2) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL clr_hdr2_seen: got no last header, expected one"); end
    clr_counters = 1'b1;
    @(negedge clk);
    clr_counters = 1'b0;
    checks++; if (!(out_wr === 1'b1 && out_ctrl === 8'h01)) begin errors++; $display("FAIL clr_eop_coincide: got wr=%b ctrl=%h expected wr=1 ctrl=01", out_wr, out_ctrl); end
    checks++; if (pkts_sent !== 32'd0) begin errors++; $display("FAIL clr_eop_pkts: got %0d expected 0", pkts_sent); end
    wait_idle(100, 1'b0, ok);
    start_gen(16'd1, 8'd1, 8'd5, PAT);
    wait_idle(100, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clr_timeout: busy stuck 1, expected 0"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (act_q.size() == 0) begin errors++; $display("FAIL clr_word: missing, expected %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin errors++; $display("FAIL clr_word: got %h expected %h", a, e); end end
    end
    checks++; if (pkts_sent !== 32'd1) begin errors++; $display("FAIL clr_pkts_final: got %0d expected 1", pkts_sent); end
    $display("reset_clear: reset mid-header and clear at EOP done, pkts_sent=%0d", pkts_sent);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_multi();
    test_stop();
    test_boundary();
    test_reset_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ids_pkt_gen.md
Name: ids_pkt_gen

Overview:
- Packet transmitter for the user data path. It produces NetFPGA-format test packets on a standard out_data/out_ctrl/out_wr/out_rdy interface so the downstream ids matcher can be stimulated from the board.
- Each packet has a module header, three header words and N payload words. A 7-byte match pattern can be placed at a chosen payload word.
- Software registers, wired by the parent, configure the block and start/stop generation. The block reports a sent-packet count back to the parent.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; only 64 is supported.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width in bits.
- LEN_WIDTH, 8, width of the payload word count.
- IFG_CYCLES, 4, number of idle cycles between consecutive packets; 0 is allowed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- out_data  out  DATA_WIDTH  packet word
- out_ctrl  out  CTRL_WIDTH  word ctrl byte
- out_wr  out  1  word valid strobe
- out_rdy  in  1  downstream may accept a word
- gen_start  in  1  pulse; latches the config and begins generation
- gen_stop  in  1  pulse; finishes the current packet, then goes idle
- clr_counters  in  1  clears pkts_sent and seq_num
- cfg_pkt_count  in  16  number of packets to send; 0 means continuous
- cfg_payload_words  in  LEN_WIDTH  payload words per packet; 0 is treated as 1
- cfg_insert_word  in  LEN_WIDTH  payload word index (0-based) that carries the pattern; if ≥ payload words, no insertion
- cfg_pattern  in  56  7-byte pattern
- busy  out  1  FSM is not in IDLE
- pkts_sent  out  32  packets fully emitted; wraps
- gen_la_data  out  72  debug bus (see Optional Feature)
- gen_la_trigger  out  1  debug trigger

Behaviour:
- Reset values: all outputs are 0. State is IDLE, seq_num = 0, remaining = 0.
- Outputs out_data, out_ctrl and out_wr are registered.
  - A word is emitted (out_wr=1) in cycle N+1 only if the FSM is in a sending state and out_rdy=1 in cycle N.
  - Otherwise out_wr=0 and out_data/out_ctrl hold their last value.
  - The word index advances only on emission.
- States: IDLE, MODHDR, HDR, PAYLOAD, GAP.
- IDLE:
  - When gen_start=1, latch all cfg_* inputs, set remaining = cfg_pkt_count, and go to MODHDR.
  - gen_stop is ignored in IDLE.
  - gen_start outside IDLE is ignored.
- MODHDR: emit one word with ctrl = 0xFF and data = {48'h0, byte_len[15:0]}.
  - byte_len = (3 + P) * 8, where P is the effective payload word count.
  - Arithmetic is 16-bit and truncates.
  - Then go to HDR with hdr_idx = 0.
- HDR: emit 3 words with ctrl = 0x00 and data = {16'hA5A5, seq_num, 29'h0, hdr_idx[2:0]}.
  - After hdr_idx = 2, go to PAYLOAD with pl_idx = 0.
- PAYLOAD: emit P words.
  - Pattern word (pl_idx == insert_word): data = {cfg_pattern, 8'h00}.
  - All other payload words: data = {seq_num, 8'h5A, pl_idx (zero-extended to 40 bits)}.
  - ctrl = 0x00 for every word except the last (pl_idx == P-1), which has ctrl = 0x01.
  - When the last word is emitted:
    - pkts_sent++ and seq_num++, both wrapping.
    - If remaining != 0, decrement remaining.
    - Go to GAP.
- GAP: wait IFG_CYCLES cycles; out_wr = 0 regardless of out_rdy. Then:
  - Go to IDLE if a stop is pending, or if remaining hit 0 in finite mode (cfg_pkt_count != 0).
  - Otherwise go to MODHDR.
  - With IFG_CYCLES = 0, the next module header may follow the EOP word back-to-back.
- gen_stop: a pulse in any sending state sets stop_pending. The packet always completes; it is never truncated. stop_pending clears on entry to IDLE.
- clr_counters:
  - Zeroes pkts_sent and seq_num on the next edge.
  - If it coincides with an EOP emission, the clear wins and both are 0.
  - A packet already in flight keeps its latched seq_num in its header words.
- busy = (state != IDLE).
- Reset mid-packet: the next edge forces IDLE and out_wr=0. The truncated packet is accepted as reset behaviour.
- out_rdy deasserted mid-packet: the FSM stalls and no words are skipped or duplicated.

Optional Feature:
- Macro: IDS_PKT_GEN_LA_EN.
- Defined:
  - gen_la_data = {out_ctrl, out_data[63:32], state[2:0], hdr_idx[2:0], pl_idx[7:0], busy, stop_pending, out_rdy, out_wr, 16'h0}.
  - gen_la_trigger = out_wr.
  - Both are registered with the same timing as out_wr.
- Undefined: gen_la_data = 0 and gen_la_trigger = 0, with no added logic.

Test Plan:
- Basic packet: out_rdy=1, pkt_count=1, payload=2, insert=0, pattern=56'h11223344556677, start.
  - 6 words: FF/0x28, three 0x00 headers with seq 0, 0x00 payload with data 64'h1122334455667700, then ctrl 0x01.
  - Then busy falls and pkts_sent=1.
- Backpressure: same configuration with out_rdy toggled every cycle.
  - Identical 6-word sequence, with no word emitted in a cycle after out_rdy=0.
- Multiple packets: pkt_count=3, IFG_CYCLES=4.
  - seq 0,1,2; exactly 4 idle cycles between each EOP and the next FF.
  - pkts_sent=3, then IDLE.
- Continuous with stop: pkt_count=0; pulse gen_stop mid-payload of packet 5.
  - Packet 5 completes; pkts_sent=5 (seq 0–4); then IDLE with no further out_wr.
- Boundary configuration: payload=0, insert=7.
  - One payload word with ctrl 0x01 and no pattern; byte_len=0x20.
- Reset and clear: reset in an HDR word → out_wr=0 next cycle, busy=0.
  - clr_counters coincident with EOP → pkts_sent=0.
